// File: rtl/pipe_mul_unit.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with stall, flush and in-flight hazard check.
// Optional accepted-operation counter on port perf_ops is enabled by defining PIPE_MUL_PERF_EN.
module pipe_mul_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  input  logic [TAG_W-1:0] hz_rs1,
  input  logic [TAG_W-1:0] hz_rs2,
  output logic             hz_hit
`ifdef PIPE_MUL_PERF_EN
  ,
  output logic [31:0]      perf_ops
`endif
);

  // Internal product stages; the final stage is the output register itself.
  localparam int NI = (STAGES > 1) ? STAGES - 1 : 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // Extending both operands to 2*XLEN gives the same low 2*XLEN product bits
  // as the (XLEN+1)-bit signed multiply, since truncation is modular.
  function automatic logic [2*XLEN-1:0] full_product(input logic [1:0] op,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
    logic               sa;
    logic               sb;
    logic signed [2*XLEN-1:0] ea;
    logic signed [2*XLEN-1:0] eb;
    logic signed [2*XLEN-1:0] p;
    sa = ((op == OP_MULH) || (op == OP_MULHSU)) && a[XLEN-1];
    sb = (op == OP_MULH) && b[XLEN-1];
    ea = {{XLEN{sa}}, a};
    eb = {{XLEN{sb}}, b};
    p  = ea * eb;
    return p;
  endfunction

  function automatic logic [XLEN-1:0] sel_half(input logic [1:0] op,
                                               input logic [2*XLEN-1:0] prod);
    return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                   input logic [TAG_W-1:0] rs1,
                                   input logic [TAG_W-1:0] rs2);
    return (tag != '0) && ((tag == rs1) || (tag == rs2));
  endfunction

  logic                 accept;
  logic [2*XLEN-1:0]    prod_in;
  logic                 last_vld;
  logic [XLEN-1:0]      last_res;
  logic [TAG_W-1:0]     last_tag;

  logic [NI-1:0]        vld_p_q, vld_p_d;
  logic [2*XLEN-1:0]    prod_p_q [NI];
  logic [2*XLEN-1:0]    prod_p_d [NI];
  logic [1:0]           op_p_q   [NI];
  logic [1:0]           op_p_d   [NI];
  logic [TAG_W-1:0]     tag_p_q  [NI];
  logic [TAG_W-1:0]     tag_p_d  [NI];

  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0]     out_tag_q, out_tag_d;

  always_comb begin
    accept       = in_valid && !stall && !flush;
    prod_in      = full_product(in_op, in_a, in_b);
    vld_p_d      = vld_p_q;
    prod_p_d     = prod_p_q;
    op_p_d       = op_p_q;
    tag_p_d      = tag_p_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    // Source feeding the output register: last internal stage, or the issue port when STAGES=1.
    if (STAGES > 1) begin
      last_vld = vld_p_q[NI-1];
      last_res = sel_half(op_p_q[NI-1], prod_p_q[NI-1]);
      last_tag = tag_p_q[NI-1];
    end else begin
      last_vld = accept;
      last_res = sel_half(in_op, prod_in);
      last_tag = in_tag;
    end

    if (flush) begin
      vld_p_d     = '0;
      out_valid_d = 1'b0;
    end else if (!stall) begin
      // Stage 1 boundary: full product captured from the issue port.
      vld_p_d[0]  = (STAGES > 1) ? accept : 1'b0;
      prod_p_d[0] = prod_in;
      op_p_d[0]   = in_op;
      tag_p_d[0]  = in_tag;
      // Middle stage boundaries: product and tag shift one step.
      for (int i = 1; i < NI; i++) begin
        vld_p_d[i]  = vld_p_q[i-1];
        prod_p_d[i] = prod_p_q[i-1];
        op_p_d[i]   = op_p_q[i-1];
        tag_p_d[i]  = tag_p_q[i-1];
      end
      // Output boundary: half selection, data only updates on a valid result.
      out_valid_d = last_vld;
      if (last_vld) begin
        out_result_d = last_res;
        out_tag_d    = last_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      vld_p_q      <= vld_p_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    prod_p_q <= prod_p_d;
    op_p_q   <= op_p_d;
    tag_p_q  <= tag_p_d;
  end

  always_comb begin
    hz_hit = out_valid_q && tag_hit(out_tag_q, hz_rs1, hz_rs2);
    for (int i = 0; i < NI; i++) begin
      if (vld_p_q[i] && tag_hit(tag_p_q[i], hz_rs1, hz_rs2)) begin
        hz_hit = 1'b1;
      end
    end
  end

  assign busy       = (|vld_p_q) || out_valid_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

`ifdef PIPE_MUL_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;

  always_comb begin
    perf_ops_d = perf_ops_q + 32'(accept);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops_q <= '0;
    end else begin
      perf_ops_q <= perf_ops_d;
    end
  end

  assign perf_ops = perf_ops_q;
`endif

endmodule

// File: tb/tb_pipe_mul_unit.sv
// Directed self-checking bench for pipe_mul_unit at STAGES=2; perf counter checked when PIPE_MUL_PERF_EN is defined.
module tb_pipe_mul_unit;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [TAG_W-1:0] hz_rs1;
  logic [TAG_W-1:0] hz_rs2;
  logic             hz_hit;
`ifdef PIPE_MUL_PERF_EN
  logic [31:0]      perf_ops;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_mul_unit #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy),
    .hz_rs1     (hz_rs1),
    .hz_rs2     (hz_rs2),
    .hz_hit     (hz_hit)
`ifdef PIPE_MUL_PERF_EN
    ,
    .perf_ops   (perf_ops)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic op_test(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    issue(op, a, b, tag);
    tick();
    in_valid = 1'b0;
    chk({name, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_result"}, out_result, exp);
    chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    tick();
    chk({name, "_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_hold"}, out_result, exp);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0; hz_rs1 = '0; hz_rs2 = '0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hz", 32'(hz_hit), 32'd0);
`ifdef PIPE_MUL_PERF_EN
    chk("rst_perf", perf_ops, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Arithmetic corner cases
    op_test("mul_neg",   2'b00, 32'hFFFF_FFFE, 32'd3,        5'd7, 32'hFFFF_FFFA);
    op_test("mulh_neg",  2'b01, 32'hFFFF_FFFE, 32'd3,        5'd7, 32'hFFFF_FFFF);
    op_test("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    op_test("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    op_test("mul_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h0000_0000);
    op_test("mulh_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000);
    op_test("mulhsu_pos",2'b10, 32'h0000_0002, 32'h8000_0000, 5'd6, 32'h0000_0001);

    // Back-to-back, four ops with no bubble
    for (int i = 1; i <= 4; i++) begin
      issue(2'b00, 32'(i), 32'd10, 5'(i));
      tick();
      if (i >= 2) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_tag", 32'(out_tag), 32'(i - 1));
        chk("b2b_result", out_result, 32'(10 * (i - 1)));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_valid4", 32'(out_valid), 32'd1);
    chk("b2b_tag4", 32'(out_tag), 32'd4);
    chk("b2b_result4", out_result, 32'd40);
    tick();
    chk("b2b_idle", 32'(out_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd0);

    // Stall for three cycles mid-stream
    issue(2'b00, 32'd1, 32'd5, 5'd1);
    tick();
    issue(2'b00, 32'd2, 32'd5, 5'd2);
    tick();
    chk("st_pre_tag", 32'(out_tag), 32'd1);
    stall = 1'b1;
    issue(2'b00, 32'd3, 32'd5, 5'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_tag", 32'(out_tag), 32'd1);
      chk("st_result", out_result, 32'd5);
      chk("st_busy", 32'(busy), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("st_rel_tag2", 32'(out_tag), 32'd2);
    chk("st_rel_res2", out_result, 32'd10);
    issue(2'b00, 32'd4, 32'd5, 5'd4);
    tick();
    in_valid = 1'b0;
    chk("st_rel_tag3", 32'(out_tag), 32'd3);
    chk("st_rel_res3", out_result, 32'd15);
    tick();
    chk("st_rel_tag4", 32'(out_tag), 32'd4);
    chk("st_rel_v4", 32'(out_valid), 32'd1);
    tick();
    chk("st_end", 32'(out_valid), 32'd0);

    // Flush kills both in-flight ops and drops the concurrent issue
    issue(2'b00, 32'd3, 32'd3, 5'd3);
    tick();
    issue(2'b00, 32'd4, 32'd4, 5'd4);
    tick();
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    issue(2'b00, 32'd5, 32'd5, 5'd5);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    tick();
    chk("fl_valid2", 32'(out_valid), 32'd0);
    chk("fl_busy2", 32'(busy), 32'd0);

    // Hazard detection across stage 1 and the output register
    issue(2'b00, 32'd1, 32'd1, 5'd0);
    tick();
    issue(2'b00, 32'd2, 32'd2, 5'd9);
    tick();
    in_valid = 1'b0;
    hz_rs1 = 5'd9; hz_rs2 = 5'd0;
    #1;
    chk("hz_s1_hit", 32'(hz_hit), 32'd1);
    hz_rs1 = 5'd0; hz_rs2 = 5'd0;
    #1;
    chk("hz_tag0", 32'(hz_hit), 32'd0);
    hz_rs1 = 5'd5;
    #1;
    chk("hz_miss", 32'(hz_hit), 32'd0);
    hz_rs1 = 5'd0;
    tick();
    hz_rs2 = 5'd9;
    #1;
    chk("hz_out_hit", 32'(hz_hit), 32'd1);
    tick();
    chk("hz_gone", 32'(hz_hit), 32'd0);
    hz_rs2 = 5'd0;

    // Reset mid-stream discards everything
    issue(2'b00, 32'd7, 32'd6, 5'd6);
    tick();
    issue(2'b00, 32'd8, 32'd8, 5'd8);
    tick();
    chk("rs_pre_res", out_result, 32'd42);
    rst_n = 1'b0;
    tick();
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_result", out_result, 32'd0);
    chk("rs_tag", 32'(out_tag), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rs_after_valid", 32'(out_valid), 32'd0);
    chk("rs_after_busy", 32'(busy), 32'd0);

`ifdef PIPE_MUL_PERF_EN
    chk("perf_zero", perf_ops, 32'd0);
    issue(2'b00, 32'd1, 32'd1, 5'd1);
    tick();
    issue(2'b00, 32'd2, 32'd1, 5'd2);
    tick();
    stall = 1'b1;
    issue(2'b00, 32'd3, 32'd1, 5'd3);
    tick();
    stall = 1'b0;
    issue(2'b00, 32'd4, 32'd1, 5'd4);
    tick();
    issue(2'b00, 32'd5, 32'd1, 5'd5);
    tick();
    in_valid = 1'b0;
    chk("perf_count", perf_ops, 32'd4);
    tick();
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
